// File: rtl/button_debounce_unit.sv
// Tick generator plus sampled-level debouncer for front-panel buttons.
// out changes only after STABLE_SAMPLES consecutive ticks disagree with it.
module button_debounce_unit #(
  parameter int MAX_COUNT      = 10,
  parameter int CTR_WIDTH      = 4,
  parameter int STABLE_SAMPLES = 4,
  parameter int SAMPLE_WIDTH   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic pulse,
  output logic out,
  output logic rise
);

  localparam logic [CTR_WIDTH-1:0] TICK_LAST =
    CTR_WIDTH'(MAX_COUNT - 1);
  localparam logic [SAMPLE_WIDTH-1:0] STAB_LAST =
    SAMPLE_WIDTH'(STABLE_SAMPLES - 1);

  logic [CTR_WIDTH-1:0]    tick_cnt;
  logic [SAMPLE_WIDTH-1:0] stab_cnt;
  logic                    meta;
  logic                    sync;
  logic                    differ;
  logic                    accept;

  assign differ = sync != out;
  assign accept = pulse && differ && (stab_cnt == STAB_LAST);

  // Tick counter: wraps at MAX_COUNT-1 and raises pulse for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      pulse    <= 1'b0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      pulse    <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + CTR_WIDTH'(1);
      pulse    <= 1'b0;
    end
  end

  // Two-flop synchroniser, clocked every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= button;
      sync <= meta;
    end
  end

  // Stability counter and debounced level, advanced on ticks only.
  always_ff @(posedge clk) begin
    if (reset) begin
      stab_cnt <= '0;
      out      <= 1'b0;
    end else if (pulse) begin
      if (!differ) begin
        stab_cnt <= '0;
      end else if (stab_cnt == STAB_LAST) begin
        stab_cnt <= '0;
        out      <= sync;
      end else begin
        stab_cnt <= stab_cnt + SAMPLE_WIDTH'(1);
      end
    end
  end

  // Rising-edge strobe, high in the first cycle that out reads 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise <= 1'b0;
    end else begin
      rise <= accept && sync;
    end
  end

endmodule

// File: tb/tb_button_debounce_unit.sv
// Directed bench for button_debounce_unit: default and
// fast-tick variant instances share clock, reset and button.
module tb_button_debounce_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic button = 1'b0;
  logic pulse_a, out_a, rise_a;
  logic pulse_b, out_b, rise_b;

  int total = 0;
  int passed = 0;
  int rise_cnt = 0;
  int rise_bad = 0;
  logic out_prev = 1'b0;

  always #5 clk = ~clk;

  button_debounce_unit u_a (
    .clk   (clk),
    .reset (reset),
    .button(button),
    .pulse (pulse_a),
    .out   (out_a),
    .rise  (rise_a)
  );

  button_debounce_unit #(
    .MAX_COUNT     (5),
    .CTR_WIDTH     (4),
    .STABLE_SAMPLES(2),
    .SAMPLE_WIDTH  (3)
  ) u_b (
    .clk   (clk),
    .reset (reset),
    .button(button),
    .pulse (pulse_b),
    .out   (out_b),
    .rise  (rise_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // One cycle; inputs change and outputs are sampled on negedge.
  task automatic step();
    @(negedge clk);
    if (rise_a) rise_cnt++;
    if (rise_a !== (out_a && !out_prev)) rise_bad++;
    out_prev = out_a;
  endtask

  task automatic measure(input logic lvl, input int n,
                         output int la, output int lb);
    la = -1;
    lb = -1;
    for (int i = 1; i <= n; i++) begin
      step();
      if (la < 0 && out_a === lvl) la = i;
      if (lb < 0 && out_b === lvl) lb = i;
    end
  endtask

  initial begin
    int bad, bad_a, bad_b, first_a, first_b, la, lb;
    logic lvl;

    reset = 1'b1;
    button = 1'b0;
    bad = 0;
    repeat (100) begin
      step();
      if (out_a | rise_a | pulse_a | out_b | rise_b | pulse_b) bad++;
    end
    check("rst_quiet", bad, 0);
    check("rst_out", int'(out_a), 0);

    reset = 1'b0;
    bad_a = 0;
    bad_b = 0;
    first_a = -1;
    first_b = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (first_a < 0 && pulse_a) first_a = i;
      if (first_b < 0 && pulse_b) first_b = i;
      if (pulse_a !== (i % 10 == 0)) bad_a++;
      if (pulse_b !== (i % 5 == 0)) bad_b++;
    end
    check("pulse_first_a", first_a, 10);
    check("pulse_first_b", first_b, 5);
    check("pulse_per_a", bad_a, 0);
    check("pulse_per_b", bad_b, 0);

    bad = 0;
    rise_cnt = 0;
    repeat (50) begin
      button = 1'b0;
      repeat (20) begin
        step();
        if (out_a) bad++;
      end
      button = 1'b1;
      repeat (8) begin
        step();
        if (out_a) bad++;
      end
    end
    button = 1'b0;
    repeat (60) step();
    check("short_out", bad, 0);
    check("short_rise", rise_cnt, 0);

    rise_cnt = 0;
    lvl = 1'b0;
    for (int t = 0; t < 50; t++) begin
      lvl = ~lvl;
      button = lvl;
      measure(lvl, 50, la, lb);
      check($sformatf("long_lat_a%0d(%0d)", t, la),
            int'(la >= 33 && la <= 43), 1);
      check($sformatf("long_lat_b%0d(%0d)", t, lb),
            int'(lb >= 8 && lb <= 13), 1);
    end
    check("long_rise", rise_cnt, 25);
    check("long_end", int'(out_a), 0);

    bad = 0;
    button = 1'b1;
    repeat (25) begin
      step();
      if (out_a) bad++;
    end
    button = 1'b0;
    repeat (10) begin
      step();
      if (out_a) bad++;
    end
    button = 1'b1;
    measure(1'b1, 50, la, lb);
    check("glitch_hold", bad, 0);
    check($sformatf("glitch_lat(%0d)", la),
          int'(la >= 33 && la <= 43), 1);
    check("glitch_out", int'(out_a), 1);

    button = 1'b0;
    repeat (60) step();
    check("pre_rst_out", int'(out_a), 0);
    button = 1'b1;
    repeat (20) step();
    check("mid_out", int'(out_a), 0);
    check("mid_out_b", int'(out_b), 1);
    reset = 1'b1;
    step();
    check("mid_rst_a", int'(out_a), 0);
    check("mid_rst_b", int'(out_b), 0);
    check("mid_rst_pulse", int'(pulse_a), 0);
    reset = 1'b0;
    measure(1'b1, 60, la, lb);
    check($sformatf("rst_lat_a(%0d)", la),
          int'(la >= 33 && la <= 43), 1);
    check($sformatf("rst_lat_b(%0d)", lb),
          int'(lb >= 8 && lb <= 13), 1);
    check("rise_shape", rise_bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
